// File: rtl/vdp_seq.sv
// vdp_seq -- control sequencer for the iterative datapath.
// Each iteration walks S1..S4 and then CHK (five cycles). In CHK the datapath
// comparator flag decides whether to loop again or finish through DONE.
// Optional feature: define VDP_SEQ_WATCHDOG_EN to end a run once iter_cnt
// reaches a non-zero max_iter. That path sets the sticky timeout flag.
// Without the macro, max_iter is ignored and timeout stays 0.
module vdp_seq #(
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              c_in,
  input  logic [ITER_W-1:0] max_iter,
  output logic [2:0]        state,
  output logic [1:0]        mux_ctrl,
  output logic              sub_bit,
  output logic              load_in,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              timeout
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    CHK  = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ITER_W-1:0] r_iter_cnt;
  logic              r_timeout;
  logic              w_accept;
  logic              w_limit_hit;
  logic              w_iter_step;
  logic              w_timeout_set;

`ifdef VDP_SEQ_WATCHDOG_EN
  // Zero means the run has no iteration limit.
  assign w_limit_hit = (max_iter != '0) && (r_iter_cnt == max_iter);
`else
  logic w_unused_max_iter;
  assign w_unused_max_iter = ^max_iter;
  assign w_limit_hit       = 1'b0;
`endif

  // A run is accepted only from IDLE. Abort beats start, and reset beats both.
  assign w_accept      = (r_state == IDLE) && start && !abort && !reset;
  // The count advances only on a real S4->CHK move, never on an abort out of S4.
  assign w_iter_step   = (r_state == S4) && (w_next == CHK);
  // Natural completion (c_in=0) wins over the limit, so the limit flag needs c_in=1.
  assign w_timeout_set = (r_state == CHK) && c_in && w_limit_hit && (w_next == DONE);

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic. Abort from any busy state returns to IDLE.
  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start && !abort) w_next = S1;
      S1:      w_next = S2;
      S2:      w_next = S3;
      S3:      w_next = S4;
      S4:      w_next = CHK;
      CHK: begin
        if (!c_in)            w_next = DONE;
        else if (w_limit_hit) w_next = DONE;
        else                  w_next = S1;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (abort && (r_state != IDLE)) w_next = IDLE;
  end

  // Iteration counter and sticky timeout. Both are cleared on an accepted start
  // and otherwise hold between runs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_iter_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (w_accept) begin
      r_iter_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_iter_step && (r_iter_cnt != '1)) r_iter_cnt <= r_iter_cnt + 1'b1;
      if (w_timeout_set)                    r_timeout  <= 1'b1;
    end
  end

  // Moore decode of the datapath controls. load_in is the start-acceptance strobe.
  always_comb begin
    mux_ctrl = 2'b00;
    sub_bit  = 1'b0;
    unique case (r_state)
      S1:      mux_ctrl = 2'b00;
      S2:      mux_ctrl = 2'b01;
      S3: begin
        mux_ctrl = 2'b10;
        sub_bit  = 1'b1;
      end
      S4: begin
        mux_ctrl = 2'b11;
        sub_bit  = 1'b1;
      end
      default: mux_ctrl = 2'b00;
    endcase
  end

  assign state    = r_state;
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign load_in  = w_accept;
  assign iter_cnt = r_iter_cnt;
`ifdef VDP_SEQ_WATCHDOG_EN
  assign timeout  = r_timeout;
`else
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_vdp_seq.sv
// tb_vdp_seq -- directed self-checking bench for vdp_seq.
// Cycle k is the clock period that follows the k-th rising edge after the start
// request. Inputs change 1 ns after an edge, and outputs are checked 1 ns later.
module tb_vdp_seq;

  localparam int ITER_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic              c_in;
  logic [ITER_W-1:0] max_iter;
  logic [2:0]        state;
  logic [1:0]        mux_ctrl;
  logic              sub_bit;
  logic              load_in;
  logic              busy;
  logic              done;
  logic [ITER_W-1:0] iter_cnt;
  logic              timeout;

  int errors = 0;
  int checks = 0;

  vdp_seq #(.ITER_W(ITER_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .c_in     (c_in),
    .max_iter (max_iter),
    .state    (state),
    .mux_ctrl (mux_ctrl),
    .sub_bit  (sub_bit),
    .load_in  (load_in),
    .busy     (busy),
    .done     (done),
    .iter_cnt (iter_cnt),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected datapath controls for each step code, taken from the control table.
  function automatic logic [1:0] exp_mux(input int s);
    case (s)
      2:       return 2'b01;
      3:       return 2'b10;
      4:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic exp_sub(input int s);
    return (s == 3) || (s == 4);
  endfunction

  task automatic check_cycle(input string tag, input int s, input int it, input bit dn);
    check({tag, " state"},    32'(state),    32'(s));
    check({tag, " mux_ctrl"}, 32'(mux_ctrl), 32'(exp_mux(s)));
    check({tag, " sub_bit"},  32'(sub_bit),  32'(exp_sub(s)));
    check({tag, " busy"},     32'(busy),     32'(s != 0));
    check({tag, " done"},     32'(done),     32'(dn));
    check({tag, " load_in"},  32'(load_in),  32'd0);
    check({tag, " iter_cnt"}, 32'(iter_cnt), 32'(it));
  endtask

  task automatic check_reset_values(input string tag);
    check_cycle(tag, 0, 0, 1'b0);
    check({tag, " timeout"}, 32'(timeout), 32'd0);
  endtask

  // Backstop in case the sequence stalls. Every directed wait below is already bounded.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    int it;
    bit done_seen;

    reset = 1'b1; start = 1'b1; abort = 1'b0; c_in = 1'b1; max_iter = '0;
    next_cycle();
    next_cycle();
    #1;
    check_reset_values("reset");

    reset = 1'b0; start = 1'b0;
    next_cycle();

    // Run A: c_in=1 at the first two CHKs and 0 at the third. start is pulsed at cycle 3.
    start = 1'b1; c_in = 1'b1; max_iter = '0;
    #1;
    check("A c0 load_in", 32'(load_in), 32'd1);
    check("A c0 state",   32'(state),   32'd0);
    for (int c = 1; c <= 17; c++) begin
      next_cycle();
      start = (c == 3);
      c_in  = (c != 15);
      #1;
      if (c == 16)      s = 6;
      else if (c == 17) s = 0;
      else              s = ((c - 1) % 5) + 1;
      it = (c > 15) ? 3 : c / 5;
      check_cycle($sformatf("A c%0d", c), s, it, c == 16);
    end
    check("A timeout", 32'(timeout), 32'd0);

    // start together with abort in IDLE: abort wins.
    next_cycle();
    start = 1'b1; abort = 1'b1;
    #1;
    check("SA load_in", 32'(load_in), 32'd0);
    next_cycle();
    start = 1'b0; abort = 1'b0;
    #1;
    check_cycle("SA idle", 0, 3, 1'b0);

`ifdef VDP_SEQ_WATCHDOG_EN
    // Run B: max_iter=2 with c_in held 1 ends on the limit. DONE is at cycle 11.
    next_cycle();
    start = 1'b1; c_in = 1'b1; max_iter = 16'd2;
    #1;
    check("B c0 load_in", 32'(load_in), 32'd1);
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      start = 1'b0;
      #1;
      if (c == 11)      s = 6;
      else if (c == 12) s = 0;
      else              s = ((c - 1) % 5) + 1;
      it = (c >= 10) ? 2 : c / 5;
      check_cycle($sformatf("B c%0d", c), s, it, c == 11);
    end
    check("B timeout", 32'(timeout), 32'd1);

    // Run B2: max_iter=0 means no limit. There is no done by cycle 100, then abort.
    next_cycle();
    start = 1'b1; max_iter = '0;
    #1;
    check("B2 c0 timeout held", 32'(timeout), 32'd1);
    done_seen = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      next_cycle();
      start = 1'b0;
      abort = (c == 100);
      #1;
      if (done) done_seen = 1'b1;
      if (c == 1) check("B2 c1 timeout cleared", 32'(timeout), 32'd0);
    end
    check("B2 no done", 32'(done_seen), 32'd0);
    check("B2 c100 iter_cnt", 32'(iter_cnt), 32'd20);
    next_cycle();
    abort = 1'b0;
    #1;
    check_cycle("B2 c101", 0, 20, 1'b0);
`else
    // Run B: no limit, so max_iter=2 is ignored. An abort in the CHK at cycle 20 ends the run.
    next_cycle();
    start = 1'b1; c_in = 1'b1; max_iter = 16'd2;
    #1;
    check("B c0 load_in", 32'(load_in), 32'd1);
    for (int c = 1; c <= 21; c++) begin
      next_cycle();
      start = 1'b0;
      abort = (c == 20);
      #1;
      s  = (c == 21) ? 0 : ((c - 1) % 5) + 1;
      it = (c == 21) ? 4 : c / 5;
      check_cycle($sformatf("B c%0d", c), s, it, 1'b0);
    end
    abort = 1'b0;
    check("B timeout", 32'(timeout), 32'd0);
`endif

    // Run C: reset in the S3 of iteration 2 (cycle 8), then a clean single-iteration run.
    next_cycle();
    start = 1'b1; c_in = 1'b1; max_iter = '0;
    #1;
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      start = 1'b0;
      reset = (c == 8);
      #1;
      check_cycle($sformatf("C c%0d", c), ((c - 1) % 5) + 1, c / 5, 1'b0);
    end
    next_cycle();
    reset = 1'b0;
    #1;
    check_reset_values("C after reset");

    next_cycle();
    start = 1'b1; c_in = 1'b1;
    #1;
    check("D c0 load_in", 32'(load_in), 32'd1);
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      start = 1'b0;
      c_in  = (c != 5);
      #1;
      if (c == 6)      s = 6;
      else if (c == 7) s = 0;
      else             s = c;
      check_cycle($sformatf("D c%0d", c), s, (c >= 5) ? 1 : 0, c == 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vdp_seq.md
VDP_SEQ -- requirements
Module: vdp_seq

Interface
REQ-001 Parameter ITER_W, default 16, width of iteration counter and limit.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  run request, sampled in IDLE only.
REQ-005 abort  input  1  terminate current run without done.
REQ-006 c_in  input  1  comparator flag from datapath: 1 = t < a (continue), 0 = t >= a (finished).
REQ-007 max_iter  input  ITER_W  iteration limit, 0 = unlimited.
REQ-008 state  output  3  datapath step code (IDLE=0, S1=1, S2=2, S3=3, S4=4, CHK=5, DONE=6).
REQ-009 mux_ctrl  output  2  datapath operand-mux select.
REQ-010 sub_bit  output  1  ALU mode select: 1 = subtract, 0 = add.
REQ-011 load_in  output  1  one-cycle strobe to load ext_mu/ext_dt/ext_a into the datapath.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 iter_cnt  output  ITER_W  completed iterations in current/last run.
REQ-015 timeout  output  1  sticky: last run ended on iteration limit.

Function
REQ-016 Moore FSM shall use states IDLE, S1, S2, S3, S4, CHK, DONE; state output equals current state code.
REQ-017 IDLE: start=1 and abort=0 -> S1 next cycle; load_in=1 that cycle; iter_cnt cleared to 0, timeout cleared to 0.
REQ-018 S1->S2->S3->S4->CHK unconditionally, one cycle each; iteration = 5 cycles.
REQ-019 mux_ctrl: S1=00, S2=01, S3=10, S4=11, all other states 00.
REQ-020 sub_bit=1 in S3 and S4; 0 elsewhere.
REQ-021 iter_cnt shall increment on the S4->CHK transition, saturating at all-ones.
REQ-022 CHK: c_in=0 -> DONE; else limit hit (see Configuration) -> DONE with timeout set; else -> S1.
REQ-023 When both c_in=0 and limit hit in CHK, timeout shall remain 0 (natural completion wins).
REQ-024 DONE: done=1 for exactly that cycle, then IDLE.
REQ-025 Latency: start sampled cycle 0 -> S1 cycle 1 -> CHK of iteration N at cycle 5N -> done at cycle 5N+1.
REQ-026 start while busy shall be ignored; no restart, no counter change.
REQ-027 abort=1 in any non-IDLE state (incl. DONE) -> IDLE next cycle, done not asserted; iter_cnt and timeout hold.
REQ-028 abort and start both high in IDLE: abort wins, remain IDLE, no load_in.
REQ-029 iter_cnt and timeout shall hold after DONE until next accepted start.

Reset
REQ-030 reset=1 at a clock edge -> state IDLE, mux_ctrl 00, sub_bit 0, load_in 0, busy 0, done 0, iter_cnt 0, timeout 0.
REQ-031 reset overrides start and abort; reset mid-run returns IDLE next edge with no done pulse.

Configuration
REQ-032 Macro VDP_SEQ_WATCHDOG_EN: defined -> limit hit in CHK means max_iter!=0 and iter_cnt==max_iter.
REQ-033 VDP_SEQ_WATCHDOG_EN undefined -> limit never hits; max_iter ignored; timeout tied 0; runs end only on c_in=0, abort or reset.

Verification
REQ-034 Reset, start at cycle 0, c_in=1 at first two CHKs, 0 at third -> done at cycle 16, iter_cnt=3, timeout=0, load_in only at cycle 0.
REQ-035 WATCHDOG_EN, max_iter=2, c_in held 1 -> done at cycle 11, iter_cnt=2, timeout=1; max_iter=0 same stimulus -> no done by cycle 100.
REQ-036 WATCHDOG_EN undefined, max_iter=2, c_in held 1, abort at cycle 20 -> IDLE at cycle 21, done never asserted, iter_cnt=4, timeout=0.
REQ-037 Each iteration: (state, mux_ctrl, sub_bit) = (1,00,0),(2,01,0),(3,10,1),(4,11,1),(5,00,0); busy=1 throughout.
REQ-038 start pulsed at cycle 3 of a run -> ignored, done timing unchanged; start+abort in IDLE -> stays IDLE, load_in 0.
REQ-039 reset asserted in S3 -> next cycle all outputs at reset values; subsequent start runs normally from iter_cnt=0.
